// File: rtl/riscv_pkg.sv
// Shared encodings for the fetch stage: PCSrc values, fetch FSM states and the canonical NOP.
package riscv_pkg;

  localparam logic [1:0]  PC_PLUS4  = 2'b00;
  localparam logic [1:0]  PC_TARGET = 2'b01;
  localparam logic [1:0]  PC_ALU    = 2'b10;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    DISCARD = 2'b10
  } fetch_state_e;

  // PCSrc 2'b11 aliases PC+4, so only TARGET and ALU redirect.
  function automatic logic is_redirect(input logic [1:0] src);
    return (src != PC_PLUS4) && (src != 2'b11);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order instruction buffer: power-of-2 FIFO with push/pop/flush; flush overrides push and pop.
module fetch_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Head reads as zero when empty so the consumer sees clean values.
  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, single-outstanding imem fetch, in-order buffer of {instr, pc}.
// Build option FETCH_MISALIGN_TRAP_EN: a misaligned redirect target sets sticky misalign and halts fetch.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] alu_result,
  output logic            misalign
);
  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned EW = 32 + XLEN;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] new_pc;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic            retire;
  logic            redirect;
  logic            push;
  logic            room;
  logic            halt;
  logic            issue;

  assign retire     = instr_valid & instr_ready;
  assign redirect   = retire & is_redirect(pc_src);
  assign raw_target = (pc_src == PC_TARGET) ? pc_target : (alu_result & ~XLEN'(1));
  assign push       = (state == WAIT) & imem_rvalid;
  // Room after this cycle's pop: a pop implies a non-empty buffer.
  assign room       = (count < CW'(BUF_DEPTH)) | retire;
  assign issue      = (state == IDLE) & ~redirect & ~halt & room;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic bad_target;
  assign bad_target = redirect & (raw_target[1:0] != 2'b00);
  assign new_pc     = raw_target;
  assign halt       = misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (bad_target) begin
      misalign <= 1'b1;
    end
  end
`else
  assign new_pc   = raw_target & ~XLEN'(3);
  assign halt     = 1'b0;
  assign misalign = 1'b0;
`endif

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (EW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (retire),
    .flush (redirect),
    .wdata ({imem_rdata, imem_addr}),
    .rdata (head),
    .count (count)
  );

  assign instr_valid       = (count != '0);
  assign {instr, instr_pc} = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      fetch_pc  <= RESET_PC;
    end else begin
      imem_req <= 1'b0;
      if (redirect) begin
        fetch_pc <= new_pc;
      end else if (push) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      // A response arriving with the redirect is already dropped by the flush,
      // so WAIT only moves to DISCARD while the response is still in flight.
      case (state)
        IDLE: begin
          if (issue) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state <= IDLE;
          end else if (redirect) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
